// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline register sequencing controller:
// FSM state encoding, default drain length and the x0 register index.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } ctrl_state_e;

  // Cycles the halting instruction needs to move from ID/EX to retirement.
  localparam int DRAIN_CYCLES_DEF = 3;

  // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
  localparam int X0_IDX = 0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard comparator: flags a load in ID/EX whose
// destination is read by the instruction currently in IF/ID.
module load_use_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  idex_mem_read,
  input  logic [REG_ADDR_W-1:0] idex_rd,
  input  logic [REG_ADDR_W-1:0] ifid_rs1,
  input  logic [REG_ADDR_W-1:0] ifid_rs2,
  input  logic                  ifid_uses_rs1,
  input  logic                  ifid_uses_rs2,
  output logic                  lu
);

  logic [REG_ADDR_W-1:0] src   [2];
  logic [1:0]            uses;
  logic [1:0]            hit;

  assign src[0] = ifid_rs1;
  assign src[1] = ifid_rs2;
  assign uses   = {ifid_uses_rs2, ifid_uses_rs1};

  // One comparator per source operand; only operands actually read count.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign hit[gi] = uses[gi] && (src[gi] == idex_rd);
    end
  endgenerate

  assign lu = idex_mem_read && (idex_rd != REG_ADDR_W'(X0_IDX)) && (|hit);

endmodule

// File: rtl/pipeline_reg_ctrl.sv
// Sequencing controller for the PC and the four pipeline registers.
// Resolves memory freeze, branch flush, load-use stall and ecall
// halt/drain/resume, and keeps saturating stall/flush counters.
module pipeline_reg_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter int CNT_W        = 32,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  idex_mem_read,
  input  logic [REG_ADDR_W-1:0] idex_rd,
  input  logic [REG_ADDR_W-1:0] ifid_rs1,
  input  logic [REG_ADDR_W-1:0] ifid_rs2,
  input  logic                  ifid_uses_rs1,
  input  logic                  ifid_uses_rs2,
  input  logic                  ex_branch_taken,
  input  logic                  mem_busy,
  input  logic                  halt_req,
  input  logic                  resume,
  output logic                  pc_load,
  output logic                  ifid_load,
  output logic                  idex_load,
  output logic                  exmem_load,
  output logic                  memwb_load,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  halted,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  ctrl_state_e    state_reg, state_next;
  logic [DW-1:0]  drain_reg, drain_next;
  logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;
  logic           lu;
  logic           flush_event;

  load_use_detect #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_lu (
    .idex_mem_read(idex_mem_read),
    .idex_rd      (idex_rd),
    .ifid_rs1     (ifid_rs1),
    .ifid_rs2     (ifid_rs2),
    .ifid_uses_rs1(ifid_uses_rs1),
    .ifid_uses_rs2(ifid_uses_rs2),
    .lu           (lu)
  );

  // Load/flush selects decoded from state and live inputs; all zero in reset.
  always_comb begin
    pc_load     = 1'b0;
    ifid_load   = 1'b0;
    idex_load   = 1'b0;
    exmem_load  = 1'b0;
    memwb_load  = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    flush_event = 1'b0;
    if (!rst) begin
      unique case (state_reg)
        RUN: begin
          if (mem_busy) begin
            // full freeze: everything holds, other requests wait
          end else if (ex_branch_taken) begin
            {pc_load, ifid_load, idex_load, exmem_load, memwb_load} = 5'b11111;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            flush_event = 1'b1;
          end else if (lu) begin
            {idex_load, exmem_load, memwb_load} = 3'b111;
            idex_flush = 1'b1;
          end else begin
            // normal advance; a halt request also advances so the ecall enters EX
            {pc_load, ifid_load, idex_load, exmem_load, memwb_load} = 5'b11111;
          end
        end
        DRAIN: begin
          if (!mem_busy) begin
            {idex_load, exmem_load, memwb_load} = 3'b111;
            idex_flush = 1'b1;
          end
        end
        default: begin
          // HALTED: hold everything
        end
      endcase
    end
  end

  assign halted = (state_reg == HALTED);

  // Next-state and drain counter decision.
  always_comb begin
    state_next = state_reg;
    drain_next = drain_reg;
    unique case (state_reg)
      RUN: begin
        if (!mem_busy && !ex_branch_taken && !lu && halt_req) begin
          state_next = DRAIN;
          drain_next = DW'(DRAIN_CYCLES);
        end
      end
      DRAIN: begin
        if (!mem_busy) begin
          if (drain_reg <= DW'(1)) begin
            drain_next = '0;
            state_next = HALTED;
          end else begin
            drain_next = drain_reg - DW'(1);
          end
        end
      end
      HALTED: begin
        if (resume) begin
          state_next = RUN;
        end
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  // State, drain counter and saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= RUN;
      drain_reg     <= '0;
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      drain_reg <= drain_next;
      if (!pc_load && (state_reg != HALTED) && (stall_cnt_reg != '1)) begin
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      end
      if (flush_event && (flush_cnt_reg != '1)) begin
        flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;

endmodule

// File: tb/tb_pipeline_reg_ctrl.sv
// Directed self-checking bench for pipeline_reg_ctrl.
module tb_pipeline_reg_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        idex_mem_read;
  logic [4:0]  idex_rd, ifid_rs1, ifid_rs2;
  logic        ifid_uses_rs1, ifid_uses_rs2;
  logic        ex_branch_taken, mem_busy, halt_req, resume;
  logic        pc_load, ifid_load, idex_load, exmem_load, memwb_load;
  logic        ifid_flush, idex_flush, halted;
  logic [31:0] stall_cnt, flush_cnt;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  pipeline_reg_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .idex_mem_read  (idex_mem_read),
    .idex_rd        (idex_rd),
    .ifid_rs1       (ifid_rs1),
    .ifid_rs2       (ifid_rs2),
    .ifid_uses_rs1  (ifid_uses_rs1),
    .ifid_uses_rs2  (ifid_uses_rs2),
    .ex_branch_taken(ex_branch_taken),
    .mem_busy       (mem_busy),
    .halt_req       (halt_req),
    .resume         (resume),
    .pc_load        (pc_load),
    .ifid_load      (ifid_load),
    .idex_load      (idex_load),
    .exmem_load     (exmem_load),
    .memwb_load     (memwb_load),
    .ifid_flush     (ifid_flush),
    .idex_flush     (idex_flush),
    .halted         (halted),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
  );

  wire [4:0] loads   = {pc_load, ifid_load, idex_load, exmem_load, memwb_load};
  wire [1:0] flushes = {ifid_flush, idex_flush};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-22s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    idex_mem_read   = 1'b0;
    idex_rd         = 5'd0;
    ifid_rs1        = 5'd0;
    ifid_rs2        = 5'd0;
    ifid_uses_rs1   = 1'b0;
    ifid_uses_rs2   = 1'b0;
    ex_branch_taken = 1'b0;
    mem_busy        = 1'b0;
    halt_req        = 1'b0;
    resume          = 1'b0;
  endtask

  task automatic set_lu_rs2();
    idex_mem_read = 1'b1;
    idex_rd       = 5'd5;
    ifid_rs2      = 5'd5;
    ifid_uses_rs2 = 1'b1;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    chk("rst_loads", 32'(loads), 32'h0);
    chk("rst_flushes", 32'(flushes), 32'h0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    rst = 1'b0;
    #1;

    // idle RUN for 10 cycles
    for (int i = 0; i < 10; i++) begin
      chk("idle_loads", 32'(loads), 32'h1f);
      step();
    end
    chk("idle_stall_cnt", stall_cnt, 32'd0);
    chk("idle_flush_cnt", flush_cnt, 32'd0);
    chk("idle_halted", 32'(halted), 32'd0);

    // load-use via rs2
    set_lu_rs2();
    #1;
    chk("lu_rs2_loads", 32'(loads), 32'h07);
    chk("lu_rs2_flushes", 32'(flushes), 32'h1);
    step();
    chk("lu_rs2_stall_cnt", stall_cnt, 32'd1);

    // load to x0 never stalls
    idex_rd  = 5'd0;
    ifid_rs2 = 5'd0;
    #1;
    chk("lu_x0_loads", 32'(loads), 32'h1f);
    chk("lu_x0_flushes", 32'(flushes), 32'h0);
    step();
    chk("lu_x0_stall_cnt", stall_cnt, 32'd1);

    // matching rs1 that is not read: no stall
    clear_inputs();
    idex_mem_read = 1'b1;
    idex_rd       = 5'd7;
    ifid_rs1      = 5'd7;
    #1;
    chk("rs1_unused_loads", 32'(loads), 32'h1f);
    step();
    ifid_uses_rs1 = 1'b1;
    #1;
    chk("lu_rs1_loads", 32'(loads), 32'h07);
    chk("lu_rs1_flushes", 32'(flushes), 32'h1);
    step();
    chk("lu_rs1_stall_cnt", stall_cnt, 32'd2);

    // branch overrides load-use
    clear_inputs();
    set_lu_rs2();
    ex_branch_taken = 1'b1;
    #1;
    chk("br_lu_loads", 32'(loads), 32'h1f);
    chk("br_lu_flushes", 32'(flushes), 32'h3);
    step();
    chk("br_flush_cnt", flush_cnt, 32'd1);
    chk("br_stall_cnt", stall_cnt, 32'd2);

    // mem_busy freezes over a pending branch
    clear_inputs();
    ex_branch_taken = 1'b1;
    mem_busy        = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("busy_loads", 32'(loads), 32'h0);
      chk("busy_flushes", 32'(flushes), 32'h0);
      step();
    end
    chk("busy_stall_cnt", stall_cnt, 32'd6);
    chk("busy_flush_cnt", flush_cnt, 32'd1);
    mem_busy = 1'b0;
    #1;
    chk("unbusy_br_loads", 32'(loads), 32'h1f);
    chk("unbusy_br_flushes", 32'(flushes), 32'h3);
    step();
    chk("unbusy_flush_cnt", flush_cnt, 32'd2);

    // halt request, drain with one busy cycle, halt, resume
    clear_inputs();
    halt_req = 1'b1;
    #1;
    chk("halt_req_loads", 32'(loads), 32'h1f);
    step();
    halt_req = 1'b0;
    #1;
    chk("drain1_loads", 32'(loads), 32'h07);
    chk("drain1_flushes", 32'(flushes), 32'h1);
    chk("drain1_halted", 32'(halted), 32'd0);
    step();
    mem_busy = 1'b1;
    #1;
    chk("drain_busy_loads", 32'(loads), 32'h0);
    step();
    mem_busy = 1'b0;
    #1;
    chk("drain2_loads", 32'(loads), 32'h07);
    chk("drain2_halted", 32'(halted), 32'd0);
    step();
    chk("drain3_loads", 32'(loads), 32'h07);
    chk("drain3_halted", 32'(halted), 32'd0);
    step();
    chk("halted", 32'(halted), 32'd1);
    chk("halted_loads", 32'(loads), 32'h0);
    chk("halted_stall_cnt", stall_cnt, 32'd10);
    mem_busy        = 1'b1;
    ex_branch_taken = 1'b1;
    step();
    chk("halted_hold", 32'(halted), 32'd1);
    chk("halted_stall_hold", stall_cnt, 32'd10);
    chk("halted_flush_hold", flush_cnt, 32'd2);
    resume = 1'b1;
    step();
    clear_inputs();
    #1;
    chk("resume_halted", 32'(halted), 32'd0);
    chk("resume_loads", 32'(loads), 32'h1f);
    step();

    // halt_req together with load-use: load-use first
    set_lu_rs2();
    halt_req = 1'b1;
    #1;
    chk("halt_lu_loads", 32'(loads), 32'h07);
    step();
    chk("halt_lu_stall_cnt", stall_cnt, 32'd11);
    idex_mem_read = 1'b0;
    #1;
    chk("halt_after_lu", 32'(loads), 32'h1f);
    step();
    clear_inputs();
    #1;
    chk("drain_b1_loads", 32'(loads), 32'h07);
    step();

    // reset in the second drain cycle
    rst = 1'b1;
    #1;
    chk("rst_drain_loads", 32'(loads), 32'h0);
    chk("rst_drain_flushes", 32'(flushes), 32'h0);
    step();
    chk("rst_drain_stall", stall_cnt, 32'd0);
    chk("rst_drain_flush", flush_cnt, 32'd0);
    chk("rst_drain_halted", 32'(halted), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_loads", 32'(loads), 32'h1f);
    step();
    step();
    step();
    chk("post_rst_run_loads", 32'(loads), 32'h1f);
    chk("post_rst_halted", 32'(halted), 32'd0);
    chk("post_rst_stall", stall_cnt, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
